dmem_run_arbiter: RTL
=====================

// Module: dmem_run_arbiter
// PURPOSE
//  Run-phase sequencer and DMem arbiter for the single-cycle core. Shares the one DMem port between the
//  core (ld/st) and a host port (bench/loader), which preloads operands and reads back results.
//  Gates core execution (CoreEn) around the Start/Done protocol and runs a watchdog cycle counter.
//  Sits between Ctrl/RegFile (core side) and DMem (memory side) inside the top level.
// PARAMETERS
//  AW       8     DMem address width
//  DW       8     DMem data width
//  TIMEOUT  1023  max RUN cycles before forced stop (CycleCnt compare value)
// PORTS
//  Clk       in   1   clock; all state updates on posedge
//  Reset     in   1   synchronous, active-high reset
//  Start     in   1   bench start level: high = load program/data, falling edge = begin run
//  CoreDone  in   1   core finished (ProgCtr/ALU Done)
//  CoreEn    out  1   core may advance PC / write RF this cycle
//  Done      out  1   run complete (normal or timeout), level
//  Timeout   out  1   last run ended by watchdog, level
//  Phase     out  2   IDLE=0 HOLD=1 RUN=2 FIN=3
//  CycleCnt  out  16  RUN cycles of the current/last run
//  CoreWen   in   1   core store enable
//  CoreAddr  in   AW  core DMem address
//  CoreWDat  in   DW  core store data
//  CoreRdat  out  DW  load data to core (= MemRdat, combinational)
//  HostReq   in   1   host request; held until HostAck
//  HostWen   in   1   1 = write, 0 = read; stable while HostReq
//  HostAddr  in   AW  host address; stable while HostReq
//  HostWDat  in   DW  host write data; stable while HostReq
//  HostAck   out  1   one-cycle completion pulse
//  HostRdat  out  DW  read data, valid while HostAck=1, held after
//  MemWen    out  1   to DMem Wen
//  MemAddr   out  AW  to DMem Addr
//  MemWDat   out  DW  to DMem WDat
//  MemRdat   in   DW  from DMem Rdat (asynchronous read)
// BEHAVIOUR
//  - Reset: Phase=IDLE; CoreEn, Done, Timeout, HostAck, MemWen = 0; CycleCnt=0; HostRdat=0.
//    Reset mid-run aborts immediately; DMem contents untouched; a pending ack is dropped.
//  - FSM (registered, Start edge taken from a registered copy of Start):
//    IDLE: Start=1 -> HOLD.
//    HOLD: host owns DMem, CoreEn=0. Start falls (1->0) -> RUN, CycleCnt cleared to 0 on entry.
//    RUN: core owns DMem, CoreEn=1, CycleCnt+1 per cycle (saturating at 16'hFFFF).
//      CoreDone=1 -> FIN. CycleCnt==TIMEOUT with CoreDone=0 -> FIN and Timeout=1.
//      CoreDone and the timeout in the same cycle -> FIN, Timeout=0 (done wins). Start ignored in RUN.
//    FIN: host owns DMem, CoreEn=0, Done=1, CycleCnt frozen. Start=1 -> HOLD; Done and Timeout clear.
//  - Memory mux, combinational:
//    RUN: MemAddr/MemWDat = Core*, MemWen = CoreWen.
//    Otherwise: MemAddr/MemWDat = Host*, MemWen = HostWen & accept.
//    Core stores outside RUN are discarded.
//  - Host handshake: accept = (Phase==HOLD or FIN) & HostReq & ~HostAck.
//    Write lands in DMem in the accept cycle. Read: MemRdat is registered into HostRdat in the accept cycle.
//    HostAck=1 in the cycle after accept. At most one transfer per 2 cycles.
//    HostReq in IDLE or RUN stalls (no ack) until a host-owned phase.
//  - Phase boundary: a request accepted in the last HOLD cycle still acks in the first RUN cycle,
//    with no second memory access.
// STRUCTURE
//  - cpu_pkg: phase_e enum (IDLE/HOLD/RUN/FIN), DMEM_AW/DMEM_DW constants, CYC_W=16.
//  - Sub-module run_wdog: 16-bit clear/enable/saturating counter plus TIMEOUT compare.
//  - FSM, mux and handshake stay in this module.
// TESTING
//  1 Reset mid-RUN (CycleCnt=37) -> next cycle Phase=0, CoreEn=0, CycleCnt=0, Done=0.
//  2 HOLD: host write 8'h5A@8'h10, then read @8'h10 -> each HostAck 1 cycle after accept; HostRdat=8'h5A.
//  3 Start falls; CoreDone asserted after 12 RUN cycles -> Phase=3, Done=1, Timeout=0, CycleCnt=12.
//  4 TIMEOUT=20, CoreDone held 0 -> FIN after CycleCnt==20; Timeout=1; core store in FIN leaves DMem unchanged.
//  5 HostReq held through RUN -> no ack in RUN; ack 1 cycle after FIN entry; core store 8'h33@8'h04 in RUN, host reads 8'h33.
//  6 Host request accepted in last HOLD cycle -> ack in first RUN cycle; exactly one MemWen pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and sizes for the core's run-phase sequencing and DMem sharing.
package cpu_pkg;

    // Run phases, encoded as they appear on the Phase output
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } phase_e;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;
    localparam int CYC_W   = 16;

    // Phases in which the host, not the core, owns the DMem port
    function automatic logic host_owns(input phase_e p);
        return (p == HOLD) || (p == FIN);
    endfunction

endpackage

// File: rtl/run_wdog.sv
// Watchdog cycle counter: clearable, enabled, saturating, with a compare against TIMEOUT.
module run_wdog
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    output logic [CYC_W-1:0] cnt,
    output logic             hit
);

    localparam logic [CYC_W-1:0] CNT_MAX = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] CMP_VAL = CYC_W'(TIMEOUT);

    // Count enabled cycles; clear wins over enable, saturate at all-ones
    always_ff @(posedge Clk) begin
        if (Reset || clr)
            cnt <= '0;
        else if (en && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

    assign hit = (cnt == CMP_VAL);

endmodule

// File: rtl/dmem_run_arbiter.sv
// Run-phase sequencer and DMem arbiter: gates the core around the Start/Done
// protocol, runs a watchdog, and shares the single DMem port with a host.
module dmem_run_arbiter
    import cpu_pkg::*;
#(
    parameter int AW      = DMEM_AW,
    parameter int DW      = DMEM_DW,
    parameter int TIMEOUT = 1023
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             CoreDone,
    output logic             CoreEn,
    output logic             Done,
    output logic             Timeout,
    output logic [1:0]       Phase,
    output logic [CYC_W-1:0] CycleCnt,
    input  logic             CoreWen,
    input  logic [AW-1:0]    CoreAddr,
    input  logic [DW-1:0]    CoreWDat,
    output logic [DW-1:0]    CoreRdat,
    input  logic             HostReq,
    input  logic             HostWen,
    input  logic [AW-1:0]    HostAddr,
    input  logic [DW-1:0]    HostWDat,
    output logic             HostAck,
    output logic [DW-1:0]    HostRdat,
    output logic             MemWen,
    output logic [AW-1:0]    MemAddr,
    output logic [DW-1:0]    MemWDat,
    input  logic [DW-1:0]    MemRdat
);

    phase_e phase;
    logic   start_q;
    logic   start_fall;
    logic   wd_clr;
    logic   wd_en;
    logic   wd_hit;
    logic   accept;

    assign Phase      = phase;
    assign start_fall = start_q & ~Start;

    // Counter restarts on HOLD->RUN and stops on the cycle the run ends,
    // so the frozen value is the number of RUN cycles before completion.
    assign wd_clr = (phase == HOLD) && start_fall;
    assign wd_en  = (phase == RUN) && !CoreDone && !wd_hit;

    run_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .Clk  (Clk),
        .Reset(Reset),
        .clr  (wd_clr),
        .en   (wd_en),
        .cnt  (CycleCnt),
        .hit  (wd_hit)
    );

    // Phase sequencer with registered CoreEn/Done/Timeout
    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase   <= IDLE;
            start_q <= 1'b0;
            CoreEn  <= 1'b0;
            Done    <= 1'b0;
            Timeout <= 1'b0;
        end else begin
            start_q <= Start;
            case (phase)
                IDLE: begin
                    if (Start)
                        phase <= HOLD;
                end
                HOLD: begin
                    if (start_fall) begin
                        phase  <= RUN;
                        CoreEn <= 1'b1;
                    end
                end
                RUN: begin
                    // A core finish in the timeout cycle counts as a normal finish
                    if (CoreDone || wd_hit) begin
                        phase   <= FIN;
                        CoreEn  <= 1'b0;
                        Done    <= 1'b1;
                        Timeout <= !CoreDone;
                    end
                end
                FIN: begin
                    if (Start) begin
                        phase   <= HOLD;
                        Done    <= 1'b0;
                        Timeout <= 1'b0;
                    end
                end
                default: phase <= IDLE;
            endcase
        end
    end

    // Host may start a transfer only in a host-owned phase and never back-to-back
    assign accept = host_owns(phase) && HostReq && !HostAck;

    // DMem port steering: core during RUN, host otherwise
    always_comb begin
        MemAddr = HostAddr;
        MemWDat = HostWDat;
        MemWen  = HostWen & accept;
        if (phase == RUN) begin
            MemAddr = CoreAddr;
            MemWDat = CoreWDat;
            MemWen  = CoreWen;
        end
    end

    assign CoreRdat = MemRdat;

    // Host completion pulse and read-data capture in the accept cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            HostAck  <= 1'b0;
            HostRdat <= '0;
        end else begin
            HostAck <= accept;
            if (accept && !HostWen)
                HostRdat <= MemRdat;
        end
    end

endmodule
